arc4_encrypt: RTL and testbench
===============================

Name: arc4_encrypt

Overview:
- Encryption counterpart of the ARC4 decrypt path: reads a length-prefixed plaintext message from pt_mem and writes the matching length-prefixed ciphertext into ct_mem.
- Generates the ARC4 keystream itself (S-box init, KSA, PRGA) through an external single-port 256x8 s_mem.
- Sits beside the existing ct_mem/pt_mem instances, so the board can build ciphertext images that the decrypt path then consumes.

Parameters:
- KEY_BYTES, 3, key length in bytes; key byte i mod KEY_BYTES is indexed big-endian (byte 0 = key[23:16]).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  start request, sampled only while rdy=1
- rdy  out  1  idle / ready for a new request
- key  in  8*KEY_BYTES  cipher key, captured on accepted start
- pt_addr  out  8  plaintext memory address
- pt_rddata  in  8  plaintext read data, valid 1 cycle after pt_addr
- ct_addr  out  8  ciphertext memory address
- ct_wrdata  out  8  ciphertext write data
- ct_wren  out  1  ciphertext write strobe
- s_addr  out  8  S-box memory address
- s_rddata  in  8  S-box read data, valid 1 cycle after s_addr
- s_wrdata  out  8  S-box write data
- s_wren  out  1  S-box write strobe

Behaviour:
- Reset (rst high at a clock edge): next cycle rdy=1, ct_wren=0, s_wren=0, all addresses 0, ct_wrdata=0, s_wrdata=0, internal i/j/k cleared, state IDLE. Reset mid-operation aborts immediately. Memory contents are then undefined, and no further writes occur.
- Handshake: en=1 while rdy=1 is accepted. key is latched on that edge, and rdy=0 from the next cycle until completion. en while busy is ignored. On the completion cycle rdy returns to 1. If en is still high then, a new operation starts on the following edge.
- States: IDLE -> INIT -> KSA -> LEN -> PRGA -> DONE -> IDLE.
- INIT:
  - One write per cycle: S[a]=a for a=0..255, ascending.
  - Exactly 256 cycles with s_wren=1.
  - The 8-bit counter wraps 255->0 to exit.
- KSA:
  - j=0. For i=0..255: read S[i]; j=(j+S[i]+key[i mod KEY_BYTES]) mod 256; read S[j]; write S[i]=old S[j]; write S[j]=old S[i].
  - All sums truncate to 8 bits.
  - When i==j, both writes hit the same address and the value is unchanged.
  - Reads always wait the 1-cycle latency.
- LEN:
  - Read pt[0] = L. Write ct[0]=L, with one ct_wren pulse.
  - L=0: go straight to DONE; ct[0] is the only ct write.
- PRGA:
  - i=j=0. For k=1..L: i=i+1; j=j+S[i]; swap S[i],S[j]; pad=S[(S[i]+S[j]) mod 256]; read pt[k]; write ct[k]=pt[k]^pad.
  - L=255 reaches k=255 with no wrap past 255.
- Write ordering:
  - ct writes are single-cycle pulses at strictly ascending addresses 0..L, exactly once each.
  - ct_wren and s_wren are never asserted in the same cycle as a read whose data is consumed from that same memory on the next cycle.
- Latency bound: total busy cycles ≤ 256 + 256*6 + 4 + 9*L. The bench checks this bound, not an exact count.
- DONE: one cycle, all strobes low, then IDLE with rdy=1.

Decomposition:
- arc4_pkg:
  - state enum (IDLE, INIT, KSA_*, LEN_*, PRGA_*, DONE)
  - MEM_DEPTH=256
  - ADDR_W=8
  - default KEY_BYTES
- Sub-module arc4_sbox_sched:
  - Owns INIT and KSA sequencing and drives the s_mem port during those phases.
  - Handshakes with the top via start/done pulses.
- The top arc4_encrypt owns the handshake, LEN and PRGA, and the s_mem port mux.

Test Plan:
- Known vector:
  - Stimulus: key=24'h4B6579 ("Key"); pt = 09 50 6C 61 69 6E 74 65 78 74 ("Plaintext"); pulse en.
  - Required: ct = 09 BB F3 16 E8 D9 40 AF 0A D3; rdy returns to 1; exactly 10 ct_wren pulses.
- Zero length:
  - Stimulus: pt[0]=00, any key.
  - Required: ct[0]=00; no other ct writes; rdy returns to 1 after INIT+KSA+LEN.
- Round trip:
  - Stimulus: key=24'h000018; 255-byte random pt; encrypt, then copy ct back to pt and encrypt again.
  - Required: second ct equals the original pt byte-for-byte; address 255 is written once; no wrap.
- S-box check:
  - Stimulus: after INIT with key=24'h000000, inspect s_mem.
  - Required: s_mem is a permutation of 0..255; a monitor sees exactly 256 ascending INIT writes first.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during PRGA at k=3.
  - Required: next cycle rdy=1 and all strobes 0; no further ct writes; a fresh request then produces the correct known-vector output.
- Handshake:
  - Stimulus: pulse en while busy; hold en high through completion.
  - Required: the busy-time pulse is ignored; the new run starts the cycle after rdy=1, with key re-latched.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types and sizes for the ARC4 encrypt datapath and its S-box scheduler.
package arc4_pkg;

  localparam int MEM_DEPTH     = 256;
  localparam int ADDR_W        = 8;
  localparam int DEF_KEY_BYTES = 3;

  typedef enum logic [4:0] {
    IDLE,
    INIT,
    KSA_WAIT_I,
    KSA_GET_I,
    KSA_WAIT_J,
    KSA_GET_J,
    KSA_WR_J,
    KSA_NEXT,
    LEN_WAIT,
    LEN_GET,
    LEN_WR,
    PRGA_WAIT_I,
    PRGA_GET_I,
    PRGA_WAIT_J,
    PRGA_GET_J,
    PRGA_WR_J,
    PRGA_PAD,
    PRGA_WAIT_PAD,
    PRGA_GET_PAD,
    PRGA_WR,
    DONE
  } arc4_state_t;

endpackage

// File: rtl/arc4_sbox_sched.sv
// S-box identity fill followed by the key schedule, driving s_mem directly.
// Latency: 256 fill cycles + 6 cycles per KSA index; done pulses during the final S[j] write.
// Backpressure: none; start is only honoured while idle and runs to completion.
module arc4_sbox_sched
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = DEF_KEY_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [7:0]             s_rddata,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  output logic                   done
);

  arc4_state_t state;
  logic [7:0]  i;
  logic [7:0]  j;
  logic [7:0]  si;
  logic [7:0]  kidx;
  logic [7:0]  key_byte;
  logic [7:0]  j_nxt;

  // kidx tracks i mod KEY_BYTES; byte 0 is the most significant key byte.
  always_comb begin
    key_byte = 8'd0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == 8'(b)) key_byte = key[(KEY_BYTES-1-b)*8 +: 8];
    end
  end

  assign j_nxt = j + s_rddata + key_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      i        <= 8'd0;
      j        <= 8'd0;
      si       <= 8'd0;
      kidx     <= 8'd0;
      s_addr   <= '0;
      s_wrdata <= 8'd0;
      s_wren   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            i        <= 8'd0;
            s_addr   <= '0;
            s_wrdata <= 8'd0;
            s_wren   <= 1'b1;
            state    <= INIT;
          end
        end
        INIT: begin
          i        <= i + 8'd1;
          s_addr   <= i + 8'd1;
          s_wrdata <= i + 8'd1;
          if (i == 8'(MEM_DEPTH-1)) begin
            s_wren <= 1'b0;
            s_addr <= '0;
            j      <= 8'd0;
            kidx   <= 8'd0;
            state  <= KSA_WAIT_I;
          end
        end
        KSA_WAIT_I: state <= KSA_GET_I;
        KSA_GET_I: begin
          si     <= s_rddata;
          j      <= j_nxt;
          s_addr <= j_nxt;
          state  <= KSA_WAIT_J;
        end
        KSA_WAIT_J: state <= KSA_GET_J;
        KSA_GET_J: begin
          s_addr   <= i;
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
          state    <= KSA_WR_J;
        end
        KSA_WR_J: begin
          s_addr   <= j;
          s_wrdata <= si;
          done     <= (i == 8'hFF);
          state    <= KSA_NEXT;
        end
        KSA_NEXT: begin
          s_wren <= 1'b0;
          i      <= i + 8'd1;
          s_addr <= i + 8'd1;
          kidx   <= (kidx == 8'(KEY_BYTES-1)) ? 8'd0 : kidx + 8'd1;
          state  <= (i == 8'hFF) ? IDLE : KSA_WAIT_I;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encrypt: length-prefixed pt_mem -> ct_mem, keystream built in external s_mem.
// Latency: 1792 cycles of S-box setup, 4 for length/done, then 8 cycles per message byte.
// Backpressure: rdy low while busy; en is ignored until rdy returns high.
module arc4_encrypt
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = DEF_KEY_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [ADDR_W-1:0]      pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [ADDR_W-1:0]      ct_addr,
  output logic [7:0]             ct_wrdata,
  output logic                   ct_wren,
  output logic [ADDR_W-1:0]      s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren
);

  arc4_state_t            state;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             i, j, k, len, si, sj, pt_byte;
  logic [ADDR_W-1:0]      s_addr_q;
  logic [7:0]             s_wrdata_q;
  logic                   s_wren_q;
  logic                   accept;
  logic [ADDR_W-1:0]      sch_addr;
  logic [7:0]             sch_wrdata;
  logic                   sch_wren;
  logic                   sch_done;

  assign accept = rdy & en;

  arc4_sbox_sched #(.KEY_BYTES(KEY_BYTES)) u_sched (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .key      (key_q),
    .s_rddata (s_rddata),
    .s_addr   (sch_addr),
    .s_wrdata (sch_wrdata),
    .s_wren   (sch_wren),
    .done     (sch_done)
  );

  // The scheduler owns s_mem for the whole INIT+KSA span, including its final write cycle.
  assign s_addr   = (state == INIT) ? sch_addr   : s_addr_q;
  assign s_wrdata = (state == INIT) ? sch_wrdata : s_wrdata_q;
  assign s_wren   = (state == INIT) ? sch_wren   : s_wren_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rdy        <= 1'b1;
      key_q      <= '0;
      i          <= 8'd0;
      j          <= 8'd0;
      k          <= 8'd0;
      len        <= 8'd0;
      si         <= 8'd0;
      sj         <= 8'd0;
      pt_byte    <= 8'd0;
      pt_addr    <= '0;
      ct_addr    <= '0;
      ct_wrdata  <= 8'd0;
      ct_wren    <= 1'b0;
      s_addr_q   <= '0;
      s_wrdata_q <= 8'd0;
      s_wren_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            key_q <= key;
            rdy   <= 1'b0;
            state <= INIT;
          end
        end
        INIT: begin
          if (sch_done) begin
            pt_addr <= '0;
            state   <= LEN_WAIT;
          end
        end
        LEN_WAIT: state <= LEN_GET;
        LEN_GET: begin
          len       <= pt_rddata;
          ct_addr   <= '0;
          ct_wrdata <= pt_rddata;
          ct_wren   <= 1'b1;
          if (pt_rddata == 8'd0) begin
            state <= LEN_WR;
          end else begin
            i        <= 8'd1;
            j        <= 8'd0;
            k        <= 8'd1;
            s_addr_q <= 8'd1;
            pt_addr  <= 8'd1;
            state    <= PRGA_WAIT_I;
          end
        end
        PRGA_WAIT_I: begin
          ct_wren <= 1'b0;
          state   <= PRGA_GET_I;
        end
        PRGA_GET_I: begin
          si       <= s_rddata;
          j        <= j + s_rddata;
          s_addr_q <= j + s_rddata;
          pt_byte  <= pt_rddata;
          state    <= PRGA_WAIT_J;
        end
        PRGA_WAIT_J: state <= PRGA_GET_J;
        PRGA_GET_J: begin
          sj         <= s_rddata;
          s_addr_q   <= i;
          s_wrdata_q <= s_rddata;
          s_wren_q   <= 1'b1;
          state      <= PRGA_WR_J;
        end
        PRGA_WR_J: begin
          s_addr_q   <= j;
          s_wrdata_q <= si;
          state      <= PRGA_PAD;
        end
        PRGA_PAD: begin
          s_wren_q <= 1'b0;
          s_addr_q <= si + sj;
          state    <= PRGA_WAIT_PAD;
        end
        PRGA_WAIT_PAD: state <= PRGA_GET_PAD;
        PRGA_GET_PAD: begin
          ct_addr   <= k;
          ct_wrdata <= pt_byte ^ s_rddata;
          ct_wren   <= 1'b1;
          if (k == len) begin
            state <= PRGA_WR;
          end else begin
            i        <= i + 8'd1;
            k        <= k + 8'd1;
            s_addr_q <= i + 8'd1;
            pt_addr  <= k + 8'd1;
            state    <= PRGA_WAIT_I;
          end
        end
        LEN_WR, PRGA_WR: begin
          ct_wren <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed bench for arc4_encrypt with behavioural pt/ct/s memories and a write monitor.
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata, s_addr, s_rddata, s_wrdata;
  logic        ct_wren, s_wren;

  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] s_mem  [256];
  logic [7:0] orig   [256];
  logic [7:0] kv_pt  [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] kv_ct  [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  int n_chk = 0;
  int n_pass = 0;

  int ct_n = 0, s_n = 0, s_idx = 0, init_bad = 0, ct_bad = 0, busy_n = 0, hits255 = 0;
  logic [7:0] ct_last = 8'd0;
  logic       rdy_d = 1'b1;

  int ct0, bad0, busy0, hit0, sn0, cnt;

  always #5 clk = ~clk;

  arc4_encrypt dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren)
  );

  always @(posedge clk) begin
    pt_rddata <= pt_mem[pt_addr];
    s_rddata  <= s_mem[s_addr];
    if (s_wren)  s_mem[s_addr]   <= s_wrdata;
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  // Free-running write/busy monitor; tests work on deltas between snapshots.
  always @(negedge clk) begin
    if (rdy_d && !rdy) s_idx = 0;
    rdy_d = rdy;
    if (!rdy) busy_n++;
    if (ct_wren) begin
      if (ct_addr != 8'd0 && ct_addr != ct_last + 8'd1) ct_bad++;
      if (ct_addr == 8'hFF) hits255++;
      ct_last = ct_addr;
      ct_n++;
    end
    if (s_wren) begin
      if (s_idx < 256 && (s_addr != s_idx[7:0] || s_wrdata != s_idx[7:0])) init_bad++;
      s_idx++;
      s_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    ct0 = ct_n; bad0 = ct_bad; busy0 = busy_n; hit0 = hits255; sn0 = s_n;
  endtask

  task automatic start(input logic [23:0] k);
    key = k;
    en  = 1'b1;
    tick();
    en  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (rdy !== 1'b1 && c < 5000) begin
      c++;
      tick();
    end
    chk({tag, " rdy returns"}, rdy, 1'b1);
  endtask

  task automatic load_kv();
    for (int a = 0; a < 10; a++) pt_mem[a] = kv_pt[a];
  endtask

  task automatic check_kv(input string tag);
    for (int a = 0; a < 10; a++) chk($sformatf("%s ct[%0d]", tag, a), ct_mem[a], kv_ct[a]);
    chk({tag, " ct writes"}, ct_n - ct0, 10);
    chk({tag, " ct order"}, ct_bad - bad0, 0);
    chk({tag, " latency bound"}, (busy_n - busy0) <= 1796 + 9*9, 1'b1);
  endtask

  initial begin
    logic seen [256];
    int   nd;
    rst = 1'b1; en = 1'b0; key = 24'h0;
    for (int a = 0; a < 256; a++) begin pt_mem[a] = 8'd0; s_mem[a] = 8'd0; ct_mem[a] = 8'd0; end
    tick(); tick();
    chk("reset rdy", rdy, 1'b1);
    chk("reset ct_wren", ct_wren, 1'b0);
    chk("reset s_wren", s_wren, 1'b0);
    chk("reset addrs", {pt_addr, ct_addr, s_addr}, 24'h0);
    chk("reset wrdata", {ct_wrdata, s_wrdata}, 16'h0);
    rst = 1'b0;
    tick();

    // S-box fill and permutation, key 0.
    load_kv(); snap();
    start(24'h000000);
    tick();
    cnt = 0;
    while (s_idx < 256 && cnt < 600) begin cnt++; tick(); end
    tick();
    nd = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] != 8'(a)) nd++;
    chk("sbox identity after init", nd, 0);
    chk("init writes ascending", init_bad, 0);
    wait_done("sbox");
    for (int a = 0; a < 256; a++) seen[a] = 1'b0;
    for (int a = 0; a < 256; a++) seen[s_mem[a]] = 1'b1;
    nd = 0;
    for (int a = 0; a < 256; a++) if (seen[a]) nd++;
    chk("sbox permutation", nd, 256);
    chk("sbox s write count", s_n - sn0, 256 + 512 + 18);

    // Known vector.
    load_kv(); snap();
    start(24'h4B6579);
    wait_done("kv");
    check_kv("kv");

    // Zero length.
    pt_mem[0] = 8'h00; snap();
    start(24'h123456);
    wait_done("zero");
    chk("zero ct[0]", ct_mem[0], 8'h00);
    chk("zero ct writes", ct_n - ct0, 1);
    chk("zero latency", (busy_n - busy0) <= 1796, 1'b1);

    // Round trip at maximum length.
    pt_mem[0] = 8'hFF;
    for (int a = 1; a < 256; a++) begin pt_mem[a] = 8'($urandom_range(0, 255)); orig[a] = pt_mem[a]; end
    snap();
    start(24'h000018);
    wait_done("rt1");
    chk("rt1 ct writes", ct_n - ct0, 256);
    chk("rt1 addr255 once", hits255 - hit0, 1);
    chk("rt1 ct order", ct_bad - bad0, 0);
    chk("rt1 ct[0]", ct_mem[0], 8'hFF);
    chk("rt1 latency bound", (busy_n - busy0) <= 1796 + 9*255, 1'b1);
    for (int a = 0; a < 256; a++) pt_mem[a] = ct_mem[a];
    snap();
    start(24'h000018);
    wait_done("rt2");
    nd = 0;
    for (int a = 1; a < 256; a++) if (ct_mem[a] != orig[a]) nd++;
    chk("rt2 plaintext recovered", nd, 0);
    chk("rt2 addr255 once", hits255 - hit0, 1);

    // Reset during PRGA at k=3.
    load_kv(); snap();
    start(24'h4B6579);
    cnt = 0;
    while ((ct_n - ct0) < 3 && cnt < 3000) begin cnt++; tick(); end
    chk("abort reached k=3", ct_n - ct0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort rdy", rdy, 1'b1);
    chk("abort strobes", {ct_wren, s_wren}, 2'b00);
    cnt = ct_n;
    repeat (50) tick();
    chk("abort no ct writes", ct_n - cnt, 0);
    snap();
    start(24'h4B6579);
    wait_done("after abort");
    check_kv("after abort");

    // Handshake: busy-time en ignored, held en restarts with a re-latched key.
    snap();
    start(24'h000000);
    repeat (50) tick();
    en = 1'b1; tick(); en = 1'b0;
    repeat (500) tick();
    key = 24'h4B6579;
    en  = 1'b1;
    wait_done("hs1");
    chk("hs1 ct writes", ct_n - ct0, 10);
    chk("hs1 latency bound", (busy_n - busy0) <= 1796 + 9*9, 1'b1);
    snap();
    tick();
    chk("hs restart rdy", rdy, 1'b0);
    en = 1'b0;
    wait_done("hs2");
    check_kv("hs2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
